// File: rtl/hydra_sram_pkg.sv
// -----------------------------------------------------------------------------
// hydra_sram_pkg
// Shared definitions for the packet SRAM read-side logic.
//   ADDR_WIDTH / PORT_WIDTH : default page-address and port-index widths
//   jt_entry_t              : jump-table entry layout {last, rsvd[3:0], next[10:0]}
//   pcr_state_t             : page_chain_reader FSM states
// -----------------------------------------------------------------------------
package hydra_sram_pkg;

  localparam int ADDR_WIDTH = 11;
  localparam int PORT_WIDTH = 4;

  typedef struct packed {
    logic        last;
    logic [3:0]  rsvd;
    logic [10:0] next;
  } jt_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } pcr_state_t;

endpackage

// File: rtl/chain_len_guard.sv
// -----------------------------------------------------------------------------
// chain_len_guard
// Counts pages walked in the current chain and flags when the page being
// presented is the last one a legal chain may contain.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_clear     : new chain accepted, restart the count at 0
//   i_incr      : a non-last page was accepted, advance the count
//   o_at_limit  : count equals MAX_PAGES-1 (current page is the MAX_PAGES-th)
// Only instantiated when CHAIN_LEN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module chain_len_guard #(
  parameter int MAX_PAGES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_incr,
  output logic o_at_limit
);

  localparam int CW = $clog2(MAX_PAGES) + 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_limit = (r_count == CW'(MAX_PAGES - 1));

endmodule

// File: rtl/page_chain_reader.sv
// -----------------------------------------------------------------------------
// page_chain_reader
// Read-side walker for the shared packet SRAM. Takes a dequeue request
// (port, head page), follows the page chain through the jump table one page
// at a time, presents each page's address and stored ECC byte downstream and,
// one cycle after each downstream acceptance, pulses the free-page interface.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : dequeue request handshake
//   req_port, req_head            : owning port, first page of the packet
//   jt_rd_en, jt_rd_addr, jt_dout : jump-table read (registered storage output)
//   ecc_rd_en, ecc_rd_addr, ecc_dout : ECC read (registered storage output)
//   page_valid/page_ready         : downstream page handshake
//   page_addr/ecc/last/port       : presented page fields
//   rd_op, rd_port, rd_addr       : free-page pulse to the SRAM state block
//   pkt_done                      : pulse with the free of the last page
//   chain_err                     : pulse with the free of an over-long chain's
//                                   final accepted page
//
// Build option: define CHAIN_LEN_CHECK_EN to abort chains longer than
// MAX_PAGES pages; otherwise chains are followed until the last flag.
// -----------------------------------------------------------------------------
module page_chain_reader
  import hydra_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = hydra_sram_pkg::ADDR_WIDTH,
  parameter int PORT_WIDTH = hydra_sram_pkg::PORT_WIDTH,
  parameter int MAX_PAGES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PORT_WIDTH-1:0] req_port,
  input  logic [ADDR_WIDTH-1:0] req_head,
  output logic                  jt_rd_en,
  output logic [ADDR_WIDTH-1:0] jt_rd_addr,
  input  logic [15:0]           jt_dout,
  output logic                  ecc_rd_en,
  output logic [ADDR_WIDTH-1:0] ecc_rd_addr,
  input  logic [7:0]            ecc_dout,
  output logic                  page_valid,
  input  logic                  page_ready,
  output logic [ADDR_WIDTH-1:0] page_addr,
  output logic [7:0]            page_ecc,
  output logic                  page_last,
  output logic [PORT_WIDTH-1:0] page_port,
  output logic                  rd_op,
  output logic [PORT_WIDTH-1:0] rd_port,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  pkt_done,
  output logic                  chain_err
);

  pcr_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [PORT_WIDTH-1:0] r_port;
  logic                  r_page_valid;

  jt_entry_t             w_jt;
  logic [ADDR_WIDTH-1:0] w_next;
  logic                  w_accept;
  logic                  w_abort;
  logic                  w_unused;

  assign w_jt     = jt_entry_t'(jt_dout);
  assign w_next   = ADDR_WIDTH'(w_jt.next);
  assign w_accept = r_page_valid && page_ready;

  // The storage output registers only change on a read strobe, and no strobe
  // is issued while a page is presented, so the page's ECC byte and last flag
  // are taken straight from them. Gated so they read 0 when nothing is shown.
  assign page_valid = r_page_valid;
  assign page_ecc   = r_page_valid ? ecc_dout : 8'h00;
  assign page_last  = r_page_valid ? w_jt.last : 1'b0;

`ifdef CHAIN_LEN_CHECK_EN
  logic w_at_limit;
  logic r_chain_err;

  chain_len_guard #(
    .MAX_PAGES (MAX_PAGES)
  ) u_chain_len_guard (
    .clk        (clk),
    .rst        (rst),
    .i_clear    ((r_state == IDLE) && req_valid),
    .i_incr     (w_accept && !w_jt.last),
    .o_at_limit (w_at_limit)
  );

  // Over-long chain: the MAX_PAGES-th page is still delivered and freed, but
  // its next pointer is not followed.
  assign w_abort   = w_at_limit && !w_jt.last;
  assign chain_err = r_chain_err;
  assign w_unused  = ^w_jt.rsvd;
`else
  assign w_abort   = 1'b0;
  assign chain_err = 1'b0;
  assign w_unused  = ^{w_jt.rsvd, 1'(MAX_PAGES & 1)};
`endif

  // NOTE: every register below is assigned with <= so each one samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cur        <= '0;
      r_port       <= '0;
      r_page_valid <= 1'b0;
      req_ready    <= 1'b1;
      jt_rd_en     <= 1'b0;
      jt_rd_addr   <= '0;
      ecc_rd_en    <= 1'b0;
      ecc_rd_addr  <= '0;
      page_addr    <= '0;
      page_port    <= '0;
      rd_op        <= 1'b0;
      rd_port      <= '0;
      rd_addr      <= '0;
      pkt_done     <= 1'b0;
`ifdef CHAIN_LEN_CHECK_EN
      r_chain_err  <= 1'b0;
`endif
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below.
      jt_rd_en    <= 1'b0;
      ecc_rd_en   <= 1'b0;
      rd_op       <= 1'b0;
      pkt_done    <= 1'b0;
`ifdef CHAIN_LEN_CHECK_EN
      r_chain_err <= 1'b0;
`endif

      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_port      <= req_port;
            r_cur       <= req_head;
            req_ready   <= 1'b0;
            jt_rd_en    <= 1'b1;
            jt_rd_addr  <= req_head;
            ecc_rd_en   <= 1'b1;
            ecc_rd_addr <= req_head;
            r_state     <= FETCH;
          end
        end

        FETCH: begin
          r_page_valid <= 1'b1;
          page_addr    <= r_cur;
          page_port    <= r_port;
          r_state      <= PRESENT;
        end

        PRESENT: begin
          if (w_accept) begin
            r_page_valid <= 1'b0;
            rd_op        <= 1'b1;
            rd_addr      <= r_cur;
            rd_port      <= r_port;
            if (w_jt.last || w_abort) begin
              pkt_done  <= w_jt.last;
`ifdef CHAIN_LEN_CHECK_EN
              r_chain_err <= w_abort;
`endif
              req_ready <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_cur       <= w_next;
              jt_rd_en    <= 1'b1;
              jt_rd_addr  <= w_next;
              ecc_rd_en   <= 1'b1;
              ecc_rd_addr <= w_next;
              r_state     <= FETCH;
            end
          end
        end

        default: begin
          r_page_valid <= 1'b0;
          req_ready    <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_page_chain_reader.sv
// -----------------------------------------------------------------------------
// tb_page_chain_reader
// Directed and randomized stimulus for page_chain_reader. The jump table and
// ECC storage are modelled as arrays with registered outputs; the expected page
// sequence is obtained by walking the jump-table array from the head page.
// -----------------------------------------------------------------------------
module tb_page_chain_reader;

  localparam int AW     = 11;
  localparam int PW     = 4;
  localparam int TB_MAX = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_port;
  logic [AW-1:0] req_head;
  logic          jt_rd_en;
  logic [AW-1:0] jt_rd_addr;
  logic [15:0]   jt_dout;
  logic          ecc_rd_en;
  logic [AW-1:0] ecc_rd_addr;
  logic [7:0]    ecc_dout;
  logic          page_valid;
  logic          page_ready;
  logic [AW-1:0] page_addr;
  logic [7:0]    page_ecc;
  logic          page_last;
  logic [PW-1:0] page_port;
  logic          rd_op;
  logic [PW-1:0] rd_port;
  logic [AW-1:0] rd_addr;
  logic          pkt_done;
  logic          chain_err;

  page_chain_reader #(
    .ADDR_WIDTH (AW),
    .PORT_WIDTH (PW),
    .MAX_PAGES  (TB_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_port    (req_port),
    .req_head    (req_head),
    .jt_rd_en    (jt_rd_en),
    .jt_rd_addr  (jt_rd_addr),
    .jt_dout     (jt_dout),
    .ecc_rd_en   (ecc_rd_en),
    .ecc_rd_addr (ecc_rd_addr),
    .ecc_dout    (ecc_dout),
    .page_valid  (page_valid),
    .page_ready  (page_ready),
    .page_addr   (page_addr),
    .page_ecc    (page_ecc),
    .page_last   (page_last),
    .page_port   (page_port),
    .rd_op       (rd_op),
    .rd_port     (rd_port),
    .rd_addr     (rd_addr),
    .pkt_done    (pkt_done),
    .chain_err   (chain_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Storage model: output registers update only on a read strobe.
  logic [15:0] jt_mem  [0:2047];
  logic [7:0]  ecc_mem [0:2047];

  initial begin
    jt_dout  = 16'h0000;
    ecc_dout = 8'h00;
  end

  always @(posedge clk) begin
    if (jt_rd_en === 1'b1)  jt_dout  <= jt_mem[jt_rd_addr];
    if (ecc_rd_en === 1'b1) ecc_dout <= ecc_mem[ecc_rd_addr];
  end

  int n_checks  = 0;
  int n_pass    = 0;
  int free_count = 0;
  int exp_frees  = 0;
  logic prev_rd_op = 1'b0;

  logic [AW-1:0] chain_q[$];
  logic [AW-1:0] exp_pages[$];
  bit            exp_abort;
  bit            used[2048];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Free-pulse monitor: counts pulses and checks they are never back-to-back.
  always @(negedge clk) begin
    if (rd_op === 1'b1) begin
      free_count++;
      check("rd_op_back_to_back", 64'(prev_rd_op), 64'(0));
    end
    prev_rd_op = rd_op;
  end

  task automatic clear_used();
    foreach (used[i]) used[i] = 1'b0;
  endtask

  task automatic make_chain(input int n);
    logic [AW-1:0] a;
    chain_q.delete();
    while (chain_q.size() < n) begin
      a = AW'($urandom);
      if (!used[a]) begin
        used[a] = 1'b1;
        chain_q.push_back(a);
      end
    end
  endtask

  // Program jump table and ECC storage for the chain in chain_q.
  task automatic write_chain();
    int n;
    logic [AW-1:0] nxt;
    n = chain_q.size();
    for (int i = 0; i < n; i++) begin
      nxt = (i < n - 1) ? chain_q[i+1] : AW'($urandom);
      jt_mem[chain_q[i]]  = {(i == n - 1), 4'($urandom), nxt};
      ecc_mem[chain_q[i]] = 8'($urandom);
    end
  endtask

  // Reference walk: follow next pointers from the head until the last flag
  // (or, with the length check, until TB_MAX pages have been taken).
  task automatic model_walk(input logic [AW-1:0] head);
    logic [AW-1:0] a;
    logic [15:0]   e;
    exp_pages.delete();
    exp_abort = 1'b0;
    a = head;
    for (int k = 0; k < 2048; k++) begin
      exp_pages.push_back(a);
      e = jt_mem[a];
      if (e[15]) break;
`ifdef CHAIN_LEN_CHECK_EN
      if (exp_pages.size() == TB_MAX) begin
        exp_abort = 1'b1;
        break;
      end
`endif
      a = e[10:0];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   64'(req_ready),   64'(1));
    check({tag, "_jt_rd_en"},    64'(jt_rd_en),    64'(0));
    check({tag, "_jt_rd_addr"},  64'(jt_rd_addr),  64'(0));
    check({tag, "_ecc_rd_en"},   64'(ecc_rd_en),   64'(0));
    check({tag, "_ecc_rd_addr"}, 64'(ecc_rd_addr), 64'(0));
    check({tag, "_page_valid"},  64'(page_valid),  64'(0));
    check({tag, "_page_addr"},   64'(page_addr),   64'(0));
    check({tag, "_page_ecc"},    64'(page_ecc),    64'(0));
    check({tag, "_page_last"},   64'(page_last),   64'(0));
    check({tag, "_page_port"},   64'(page_port),   64'(0));
    check({tag, "_rd_op"},       64'(rd_op),       64'(0));
    check({tag, "_rd_port"},     64'(rd_port),     64'(0));
    check({tag, "_rd_addr"},     64'(rd_addr),     64'(0));
    check({tag, "_pkt_done"},    64'(pkt_done),    64'(0));
    check({tag, "_chain_err"},   64'(chain_err),   64'(0));
  endtask

  // Wait (bounded) for req_ready, then present one request for one edge.
  task automatic issue_request(input logic [PW-1:0] port, input logic [AW-1:0] head);
    int waited;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_before_request", 64'(req_ready), 64'(1));
    page_ready = 1'b1;
    req_valid  = 1'b1;
    req_port   = port;
    req_head   = head;
    @(negedge clk);
    req_valid  = 1'b0;
    req_port   = PW'($urandom);
    req_head   = AW'($urandom);
  endtask

  // Entered at the negedge of the FETCH cycle; leaves at the negedge of the
  // cycle carrying this page's free pulse.
  task automatic page_step(input logic [PW-1:0] port, input logic [AW-1:0] addr,
                           input bit last, input bit err, input int stall);
    check("fetch_jt_rd_en",    64'(jt_rd_en),    64'(1));
    check("fetch_jt_rd_addr",  64'(jt_rd_addr),  64'(addr));
    check("fetch_ecc_rd_en",   64'(ecc_rd_en),   64'(1));
    check("fetch_ecc_rd_addr", 64'(ecc_rd_addr), 64'(addr));
    check("fetch_page_valid",  64'(page_valid),  64'(0));
    check("fetch_req_ready",   64'(req_ready),   64'(0));
    page_ready = (stall == 0);
    @(negedge clk);
    check("present_page_valid", 64'(page_valid), 64'(1));
    check("present_page_addr",  64'(page_addr),  64'(addr));
    check("present_page_ecc",   64'(page_ecc),   64'(ecc_mem[addr]));
    check("present_page_last",  64'(page_last),  64'(last));
    check("present_page_port",  64'(page_port),  64'(port));
    check("present_req_ready",  64'(req_ready),  64'(0));
    check("present_jt_rd_en",   64'(jt_rd_en),   64'(0));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_page_valid", 64'(page_valid), 64'(1));
      check("stall_page_addr",  64'(page_addr),  64'(addr));
      check("stall_page_ecc",   64'(page_ecc),   64'(ecc_mem[addr]));
      check("stall_page_last",  64'(page_last),  64'(last));
      check("stall_jt_rd_en",   64'(jt_rd_en),   64'(0));
      check("stall_ecc_rd_en",  64'(ecc_rd_en),  64'(0));
      check("stall_rd_op",      64'(rd_op),      64'(0));
    end
    page_ready = 1'b1;
    @(negedge clk);
    check("free_rd_op",      64'(rd_op),      64'(1));
    check("free_rd_addr",    64'(rd_addr),    64'(addr));
    check("free_rd_port",    64'(rd_port),    64'(port));
    check("free_pkt_done",   64'(pkt_done),   64'(last));
    check("free_chain_err",  64'(chain_err),  64'(err));
    check("free_page_valid", 64'(page_valid), 64'(0));
    check("free_req_ready",  64'(req_ready),  64'(last || err));
  endtask

  task automatic walk_expected(input logic [PW-1:0] port, input int stall_idx, input int stall_len);
    int n;
    n = exp_pages.size();
    for (int i = 0; i < n; i++) begin
      page_step(port, exp_pages[i], (i == n - 1) && !exp_abort, (i == n - 1) && exp_abort,
                (i == stall_idx) ? stall_len : 0);
    end
    exp_frees += n;
  endtask

  task automatic run_chain(input logic [PW-1:0] port, input int stall_idx, input int stall_len);
    issue_request(port, chain_q[0]);
    model_walk(chain_q[0]);
    walk_expected(port, stall_idx, stall_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] chain_a[$];
    logic [AW-1:0] chain_b[$];
    int            frees_before;
    int            n;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_port   = '0;
    req_head   = '0;
    page_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Single-page packet.
    clear_used();
    chain_q = '{11'h010};
    write_chain();
    ecc_mem[11'h010] = 8'hA5;
    run_chain(4'd3, -1, 0);

    // Three-page chain, page_ready high throughout.
    clear_used();
    chain_q = '{11'h005, 11'h100, 11'h7FF};
    write_chain();
    run_chain(4'd7, -1, 0);

    // Backpressure: page 2 stalled for 5 cycles.
    clear_used();
    make_chain(3);
    write_chain();
    run_chain(4'd9, 1, 5);

    // Request while busy: B waits for A's last handshake.
    clear_used();
    make_chain(2);
    chain_a = chain_q;
    write_chain();
    make_chain(1);
    chain_b = chain_q;
    write_chain();
    issue_request(4'd1, chain_a[0]);
    req_valid = 1'b1;
    req_port  = 4'd12;
    req_head  = chain_b[0];
    model_walk(chain_a[0]);
    walk_expected(4'd1, -1, 0);
    @(negedge clk);
    req_valid = 1'b0;
    model_walk(chain_b[0]);
    walk_expected(4'd12, -1, 0);

    // Reset in PRESENT of page 2 of 3.
    clear_used();
    make_chain(3);
    write_chain();
    issue_request(4'd5, chain_q[0]);
    model_walk(chain_q[0]);
    page_step(4'd5, exp_pages[0], 1'b0, 1'b0, 0);
    exp_frees += 1;
    page_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_page_valid", 64'(page_valid), 64'(1));
    check("rst_mid_page_addr",  64'(page_addr),  64'(exp_pages[1]));
    #1;
    frees_before = free_count;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst        = 1'b0;
    page_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("rst_mid_no_free", 64'(free_count), 64'(frees_before));
    check("rst_mid_req_ready", 64'(req_ready), 64'(1));

`ifdef CHAIN_LEN_CHECK_EN
    // Over-long chain: only TB_MAX pages delivered and freed.
    clear_used();
    make_chain(6);
    write_chain();
    #1;
    frees_before = free_count;
    run_chain(4'd2, -1, 0);
    #1;
    check("chainlen_frees", 64'(free_count - frees_before), 64'(TB_MAX));
    check("chainlen_idle_jt_rd_en", 64'(jt_rd_en), 64'(0));
    @(negedge clk);
    check("chainlen_req_ready", 64'(req_ready), 64'(1));
    check("chainlen_page_valid", 64'(page_valid), 64'(0));
`endif

    // Randomized chains, lengths and stalls.
    for (int r = 0; r < 8; r++) begin
      clear_used();
      n = int'($urandom_range(1, 6));
      make_chain(n);
      write_chain();
      run_chain(PW'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1,
                int'($urandom_range(1, 4)));
    end

    repeat (3) @(negedge clk);
    #1;
    check("total_free_pulses", 64'(free_count), 64'(exp_frees));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
